// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-port and memory-controller signals of the arbiter, bundled as one interface.
interface sdram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              p0_req, p0_we, p0_ack, p0_err;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_ack, p1_err;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;

  logic              mem_init_fin;
  logic              mem_rd_req, mem_wr_req, mem_rd_fin, mem_wr_fin;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
    input  mem_init_fin, mem_rd_fin, mem_wr_fin, mem_rd_data,
    output mem_rd_req, mem_wr_req, mem_rd_addr, mem_wr_addr, mem_wr_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata,
    output mem_init_fin, mem_rd_fin, mem_wr_fin, mem_rd_data,
    input  mem_rd_req, mem_wr_req, mem_rd_addr, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker: on contention the port not served last wins.
module sdram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter in front of an SDRAM controller: one access in flight,
// timeout/init-loss abort, all outputs registered.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t        state, next_state;
  logic [1:0]        req_eff, grant;
  logic              last, sel, we_q, abort_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [CNT_W-1:0]  cnt;
  logic              ack0_q, ack1_q, err0_q, err1_q, rd_req_q, wr_req_q;
  logic              fin_match, timeout, abort_now, take;
  logic              we_next, rd_req_d, wr_req_d, ack0_d, ack1_d, err_d;

  // The port whose ack is showing is still holding req this cycle; hide it.
  assign req_eff = {bus.p1_req & ~ack1_q, bus.p0_req & ~ack0_q};

  sdram_arb_rr u_rr (
    .req   (req_eff),
    .last  (last),
    .grant (grant)
  );

  assign fin_match = we_q ? bus.mem_wr_fin : bus.mem_rd_fin;
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign abort_now = ((state == ISSUE) && (!bus.mem_init_fin || (!fin_match && timeout)))
                   || ((state == CAPTURE) && !bus.mem_init_fin);
  assign take      = (state == IDLE) && bus.mem_init_fin && (grant != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = ISSUE;
      ISSUE: begin
        if (abort_now)      next_state = RESP;
        else if (fin_match) next_state = we_q ? RESP : CAPTURE;
      end
      CAPTURE: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; the request lines follow the next state.
  always_comb begin
    we_next  = take ? (grant[1] ? bus.p1_we : bus.p0_we) : we_q;
    rd_req_d = (next_state == ISSUE) && !we_next;
    wr_req_d = (next_state == ISSUE) && we_next;
    ack0_d   = (state == RESP) && !sel;
    ack1_d   = (state == RESP) && sel;
    err_d    = (state == RESP) && abort_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      cnt      <= '0;
      sel      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      abort_q  <= 1'b0;
      last     <= 1'b1;
    end else begin
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err_d & ~sel;
      err1_q   <= err_d & sel;
      cnt      <= (state == ISSUE) ? cnt + CNT_W'(1) : '0;
      if (take) begin
        sel     <= grant[1];
        we_q    <= we_next;
        addr_q  <= grant[1] ? bus.p1_addr : bus.p0_addr;
        wdata_q <= grant[1] ? bus.p1_wdata : bus.p0_wdata;
      end
      if (state == IDLE)  abort_q <= 1'b0;
      else if (abort_now) abort_q <= 1'b1;
      if ((state == CAPTURE) && bus.mem_init_fin) begin
        if (sel) rdata1_q <= bus.mem_rd_data;
        else     rdata0_q <= bus.mem_rd_data;
      end
      if (abort_now) begin
        if (sel) rdata1_q <= '0;
        else     rdata0_q <= '0;
      end
      if (state == RESP) last <= sel;
    end
  end

  assign bus.mem_rd_req  = rd_req_q;
  assign bus.mem_wr_req  = wr_req_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.p0_ack      = ack0_q;
  assign bus.p1_ack      = ack1_q;
  assign bus.p0_err      = err0_q;
  assign bus.p1_err      = err1_q;
  assign bus.p0_rdata    = rdata0_q;
  assign bus.p1_rdata    = rdata1_q;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of client and memory ports.
REQ-002 Parameter DATA_W, default 32, data width of client and memory ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, max ISSUE cycles before abort.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pN_req  input  1  (N=0,1) client request level; held until pN_ack.
REQ-007 pN_we  input  1  1=write, 0=read; sampled at grant.
REQ-008 pN_addr  input  ADDR_W  byte address; sampled at grant.
REQ-009 pN_wdata  input  DATA_W  write data; sampled at grant.
REQ-010 pN_ack  output  1  one-cycle completion pulse.
REQ-011 pN_rdata  output  DATA_W  read data, valid while pN_ack is high.
REQ-012 pN_err  output  1  qualifies pN_ack: access aborted.
REQ-013 mem_init_fin  input  1  controller initialisation complete.
REQ-014 mem_rd_req, mem_wr_req  output  1 each  request levels to the controller.
REQ-015 mem_rd_addr, mem_wr_addr  output  ADDR_W  request addresses.
REQ-016 mem_wr_data  output  DATA_W  write data.
REQ-017 mem_rd_fin, mem_wr_fin  input  1 each  one-cycle completion pulses.
REQ-018 mem_rd_data  input  DATA_W  read data; stable from the cycle after mem_rd_fin.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-020 IDLE: no grant while mem_init_fin=0.
- Otherwise, on any pN_req, latch the winner's we/addr/wdata and enter ISSUE.
REQ-021 Arbitration: single requester wins.
- Both requesting: the port not served last wins.
- After reset, port 0 has priority.
REQ-022 ISSUE: drive exactly one of mem_rd_req/mem_wr_req high, selected by the latched we.
- mem_rd_addr and mem_wr_addr both carry the latched address.
- mem_wr_data carries the latched wdata.
- All four are stable for the whole ISSUE stay.
REQ-023 ISSUE + mem_wr_fin (latched we=1): the next cycle is RESP with the request deasserted.
REQ-024 ISSUE + mem_rd_fin (latched we=0): the next cycle is CAPTURE with the request deasserted.
REQ-025 CAPTURE: register mem_rd_data into the granted port's rdata, then go to RESP.
REQ-026 RESP: pulse the granted pN_ack for exactly one cycle, record the last-served port, return to IDLE.
- Read latency from grant = controller latency + 3 cycles; write = controller latency + 2.
REQ-027 A fin pulse of the wrong type, or one received outside ISSUE, is ignored.
REQ-028 Timeout: a cycle counter runs in ISSUE.
- At TIMEOUT_CYCLES with no matching fin: deassert the request, go to RESP with pN_err=1 and pN_rdata=0.
REQ-029 mem_init_fin falling while in ISSUE/CAPTURE aborts identically to a timeout on the next cycle.
REQ-030 In the IDLE cycle directly after RESP, the just-served port's req is ignored; the other port may be granted.
REQ-031 mem_rd_req and mem_wr_req are never high simultaneously.
- Neither is high outside ISSUE.

Reset
REQ-032 Reset state and outputs:
- FSM=IDLE, priority=port 0, timeout counter=0.
- All ack/err/mem_*_req outputs 0; rdata, mem address and data outputs 0.
REQ-033 Reset during ISSUE drops the memory request immediately; no ack is produced.

Structure
REQ-034 Package sdram_arb_pkg holds the FSM state encoding and the TIMEOUT_CYCLES default.
REQ-035 One sub-module, sdram_arb_rr: a 2-way round-robin picker (req[1:0], last → grant[1:0]).
REQ-036 All outputs are registered; no combinational path from mem_*_fin to pN_ack.

Verification
REQ-037 p0 write, addr 0x00001230, data 0xDEADBEEF; mem_wr_fin 5 cycles later -> mem_wr_req high for exactly 5 cycles, p0_ack 2 cycles after fin, p0_err=0.
REQ-038 p1 read, addr 0x00400000; mem_rd_fin, then mem_rd_data=0xCAFEF00D -> p1_ack 3 cycles after fin with p1_rdata=0xCAFEF00D.
REQ-039 p0 and p1 request in the same cycle, both held, 3 rounds -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-040 mem_init_fin=0 while p0_req=1 for 50 cycles -> no mem request; grant occurs the cycle after init_fin rises.
REQ-041 TIMEOUT_CYCLES=16, no fin -> mem_rd_req drops after 16 cycles, p0_ack=1 with p0_err=1, p0_rdata=0; a late mem_rd_fin is ignored.
REQ-042 Reset asserted mid-ISSUE -> mem_*_req=0 immediately, no ack; after release, priority is port 0.
